// File: rtl/ndma_pkg.sv
// ndma_pkg: shared response type, word size and stall-LFSR constants for the NanoDMA memory model
package ndma_pkg;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } ndma_resp_t;
  localparam int          NDMA_WORD_BYTES = 4;
  localparam logic [15:0] NDMA_LFSR_SEED  = 16'hACE1;
  // taps 16,14,13,11 of a left-shifting Fibonacci LFSR
  localparam logic [15:0] NDMA_LFSR_TAPS  = 16'hB400;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: small synchronous FIFO, head visible on data_o while not empty
module fifo_v3 #(
  parameter int unsigned DEPTH = 2,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output dtype data_o
);
  localparam int unsigned AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [AW-1:0]      rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  dtype [DEPTH-1:0]   mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wptr_q] = data_i;
    wptr_d = push_i ? (wptr_q == AW'(DEPTH-1) ? '0 : wptr_q + AW'(1)) : wptr_q;
    rptr_d = pop_i ? (rptr_q == AW'(DEPTH-1) ? '0 : rptr_q + AW'(1)) : rptr_q;
    cnt_d  = (push_i && !pop_i) ? cnt_q + (AW+1)'(1) :
             (!push_i && pop_i) ? cnt_q - (AW+1)'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign data_o  = mem_q[rptr_q];
endmodule

// File: rtl/ndma_delay_line.sv
// ndma_delay_line: Latency-1 stage valid/data shift register, pass-through when Latency==1
module ndma_delay_line #(
  parameter int  Latency = 1,
  parameter type T       = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);
  if (Latency == 1) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_pipe
    localparam int S = Latency - 1;
    logic [S-1:0] valid_q, valid_d;
    T     [S-1:0] data_q, data_d;
    always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      valid_d[0] = valid_i;
      data_d[0]  = data_i;
      for (int i = 1; i < S; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
    assign valid_o = valid_q[S-1];
    assign data_o  = data_q[S-1];
  end
endmodule

// File: rtl/ndma_obi_mem.sv
// ndma_obi_mem: credit-limited in-order OBI scratchpad; NDMA_MEM_STALL_EN adds LFSR grant/response stalls
import ndma_pkg::*;
module ndma_obi_mem #(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 32,
  parameter int Latency   = 1,
  parameter int RespDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int AddrBits = $clog2(NumWords);
  localparam int Lsb      = $clog2(NDMA_WORD_BYTES);
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [RespDepth:0]   out_q, out_d;
  logic [AddrBits-1:0]  idx;
  logic                 gnt_ok, rsp_ok, dec_err, pop, dl_valid, q_empty, q_full;
  ndma_resp_t           resp, dl_resp, head;
`ifdef NDMA_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & NDMA_LFSR_TAPS)};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= NDMA_LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end
  assign gnt_ok = lfsr_q[1:0] != 2'b00;
  assign rsp_ok = lfsr_q[3:2] != 2'b00;
`else
  assign gnt_ok = 1'b1;
  assign rsp_ok = 1'b1;
`endif
  assign idx     = addr_i[AddrBits+Lsb-1:Lsb];
  assign dec_err = (|addr_i[Lsb-1:0]) | (|addr_i[31:AddrBits+Lsb]);
  // registered count only: a same-cycle pop does not free a credit
  assign gnt_o   = req_i & gnt_ok & (out_q < (RespDepth+1)'(RespDepth));
  assign pop     = rvalid_o & rready_i;
  always_comb begin
    resp.err   = dec_err;
    resp.rdata = (we_i | dec_err) ? '0 : mem_q[idx];
    out_d      = (gnt_o && !pop) ? out_q + (RespDepth+1)'(1) :
                 (!gnt_o && pop) ? out_q - (RespDepth+1)'(1) : out_q;
  end
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && !dec_err)
      for (int k = 0; k < 4; k++)
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_q <= '0;
    else         out_q <= out_d;
  end
  ndma_delay_line #(.Latency(Latency), .T(ndma_resp_t)) i_dl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (gnt_o),
    .data_i  (resp),
    .valid_o (dl_valid),
    .data_o  (dl_resp)
  );
  fifo_v3 #(.DEPTH(RespDepth), .dtype(ndma_resp_t)) i_rsp_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (dl_valid & ~q_full),
    .data_i  (dl_resp),
    .pop_i   (pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .data_o  (head)
  );
  assign rvalid_o = ~q_empty & rsp_ok;
  assign rdata_o  = rvalid_o ? head.rdata : '0;
  assign err_o    = rvalid_o & head.err;
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(dl_valid && q_full));
endmodule

// File: tb/tb_ndma_obi_mem.sv
// tb_ndma_obi_mem: directed stimulus against a queue/array model of the OBI memory
module tb_ndma_obi_mem;
  localparam int NW  = 1024;
  localparam int LAT = 1;
  localparam int RD  = 2;
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          rdy;
  } exp_t;
  logic        clk_i = 0, rst_ni = 0, req_i = 0, we_i = 0, rready_i = 1;
  logic [31:0] addr_i = 0, wdata_i = 0;
  logic [3:0]  be_i = 0;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  int          checks = 0, errors = 0, cyc = 0;
  exp_t        q[$];
  logic [31:0] mm [int];

  ndma_obi_mem #(.NumWords(NW), .DataWidth(32), .Latency(LAT), .RespDepth(RD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: every granted request owes one response, in order, no earlier than grant+LAT
  always @(negedge clk_i) begin
    logic ev, eg, ee;
    logic [31:0] w;
    if (!rst_ni) begin
      q.delete();
      check("rst_rvalid", {31'b0, rvalid_o}, 0);
      check("rst_gnt", {31'b0, gnt_o}, {31'b0, req_i});
    end else begin
      ev = q.size() > 0 && q[0].rdy <= cyc;
      eg = req_i && q.size() < RD;
      check("gnt", {31'b0, gnt_o}, {31'b0, eg});
      check("rvalid", {31'b0, rvalid_o}, {31'b0, ev});
      check("rdata", rdata_o, ev ? q[0].d : 32'h0);
      check("err", {31'b0, err_o}, {31'b0, ev && q[0].e});
      if (ev && rready_i) void'(q.pop_front());
      if (eg) begin
        ee = addr_i[1:0] != 0 || addr_i >= NW * 4;
        w = addr_i >> 2;
        if (!ee && we_i) begin
          if (!mm.exists(w)) mm[w] = 0;
          for (int k = 0; k < 4; k++) if (be_i[k]) mm[w][8*k +: 8] = wdata_i[8*k +: 8];
        end
        q.push_back('{d: (ee || we_i) ? 32'h0 : (mm.exists(w) ? mm[w] : 32'h0), e: ee, rdy: cyc + LAT});
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output int g);
    req_i = 1; we_i = w; addr_i = a; be_i = b; wdata_i = d; g = -1;
    for (int i = 0; i < 50 && g < 0; i++) begin
      @(negedge clk_i);
      if (gnt_o) g = cyc;
      @(posedge clk_i); #1;
    end
    req_i = 0;
    if (g < 0) begin
      errors++;
      $display("FAIL grant_timeout: no grant for addr %h", a);
    end
  endtask

  task automatic get_resp(output logic [31:0] d, output logic e, output int r);
    r = -1; d = 0; e = 0;
    for (int i = 0; i < 50 && r < 0; i++) begin
      @(negedge clk_i);
      if (rvalid_o) begin d = rdata_o; e = err_o; r = cyc; end
      @(posedge clk_i); #1;
    end
    if (r < 0) begin
      errors++;
      $display("FAIL resp_timeout: no response");
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e, output int lat);
    int g, r;
    xfer(0, a, 4'h0, 32'h0, g);
    get_resp(d, e, r);
    lat = r - g;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, input logic exp_e);
    int g, r;
    logic [31:0] rd_d;
    logic e;
    xfer(1, a, b, d, g);
    get_resp(rd_d, e, r);
    check("wr_err", {31'b0, e}, {31'b0, exp_e});
    check("wr_rdata", rd_d, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, gcnt, vcnt, c0, g;
    #1;
    check("reset_rvalid", {31'b0, rvalid_o}, 0);
    check("reset_rdata", rdata_o, 0);
    check("reset_gnt", {31'b0, gnt_o}, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1;
    @(posedge clk_i); #1;

    wr(32'h10, 4'hF, 32'hDEADBEEF, 0);
    rd(32'h10, d, e, lat);
    check("full_word_rdata", d, 32'hDEADBEEF);
    check("full_word_err", {31'b0, e}, 0);
    check("read_latency", lat, 1);

    wr(32'h10, 4'b0001, 32'h00000055, 0);
    rd(32'h10, d, e, lat);
    check("byte_write_rdata", d, 32'hDEADBE55);

    wr(32'h10, 4'h0, 32'hFFFFFFFF, 0);
    rd(32'h10, d, e, lat);
    check("be_zero_rdata", d, 32'hDEADBE55);

    rd(32'h2, d, e, lat);
    check("misaligned_err", {31'b0, e}, 1);
    check("misaligned_rdata", d, 0);
    rd(NW * 4, d, e, lat);
    check("range_err", {31'b0, e}, 1);
    check("range_rdata", d, 0);
    wr(32'h1010, 4'hF, 32'h12345678, 1);
    rd(32'h10, d, e, lat);
    check("err_no_write", d, 32'hDEADBE55);

    // back-pressure: credits run out after RD grants
    req_i = 1; we_i = 0; addr_i = 32'h10; rready_i = 0; gcnt = 0;
    repeat (6) begin @(negedge clk_i); gcnt += gnt_o; end
    check("bp_grants", gcnt, 2);
    check("bp_gnt_low", {31'b0, gnt_o}, 0);
    check("bp_hold_data", rdata_o, 32'hDEADBE55);
    @(posedge clk_i); #1 rready_i = 1;
    repeat (4) @(negedge clk_i);
    @(posedge clk_i); #1 req_i = 0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("bp_drained", {31'b0, rvalid_o}, 0);
    @(posedge clk_i); #1;

    for (int i = 0; i < 8; i++) wr(i * 4, 4'hF, 32'h10000000 + i, 0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      req_i = 1; we_i = 0; addr_i = i * 4;
      @(negedge clk_i);
      check("b2b_gnt", {31'b0, gnt_o}, 1);
      if (i > 0) vcnt += rvalid_o;
      @(posedge clk_i); #1;
    end
    req_i = 0;
    @(negedge clk_i);
    vcnt += rvalid_o;
    check("b2b_rvalid_run", vcnt, 8);
    check("b2b_last_data", rdata_o, 32'h10000007);
    @(posedge clk_i); #1;

    // reset with two responses pending
    rready_i = 0; req_i = 1; we_i = 0; addr_i = 32'h4;
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #1 req_i = 0;
    @(negedge clk_i);
    check("pre_rst_rvalid", {31'b0, rvalid_o}, 1);
    @(posedge clk_i); #1 rst_ni = 0;
    #1 check("async_rst_rvalid", {31'b0, rvalid_o}, 0);
    @(posedge clk_i); #1 rst_ni = 1; rready_i = 1;
    c0 = cyc;
    xfer(0, 32'h0, 4'h0, 32'h0, g);
    check("post_rst_gnt_cycle", g, c0);
    get_resp(d, e, lat);
    check("post_rst_rdata", d, 32'h10000000);
    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
